// File: rtl/truth_table_sweeper.sv
// Purpose : exhaustive truth-table sweeper; drives every N-bit vector to a combinational
//           DUT, samples its 1-bit response and tallies mismatches against EXPECTED.
// Latency : x/busy valid one edge after start; each vector held HOLD cycles; done after 2^N*HOLD.
// Backpressure: none; start is ignored while a sweep is running.
// Ports   : clk, rst (async, active-high), start -> begin sweep; x -> DUT stimulus;
//           f <- DUT response; busy/done/pass status; err_count, err_valid, first_err_idx results.
module truth_table_sweeper #(
    parameter int                N        = 3,
    parameter int                HOLD     = 20,
    parameter logic [(1<<N)-1:0] EXPECTED = 8'hE8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] x,
    input  logic         f,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         err_valid,
    output logic [N-1:0] first_err_idx
);

    // Hold counter only needs to reach HOLD-1; keep at least one bit for HOLD==1.
    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N-1:0]  VEC_LAST  = {N{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  vec_q;
    logic [HW-1:0] hold_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [N:0]    err_cnt_q;
    logic          err_vld_q;
    logic [N-1:0]  first_idx_q;

    logic          exp_bit;
    logic          sample;
    logic          mismatch;
    logic [N:0]    err_cnt_d;
    logic          err_vld_d;
    logic [N-1:0]  first_idx_d;

    always_comb begin
        exp_bit     = EXPECTED[vec_q];
        sample      = (state_q == S_APPLY) && (hold_q == HOLD_LAST);
        // Case inequality so an X/Z response is scored as a mismatch.
        mismatch    = sample && (f !== exp_bit);
        err_cnt_d   = err_cnt_q;
        err_vld_d   = err_vld_q;
        first_idx_d = first_idx_q;
        if (mismatch) begin
            err_cnt_d = err_cnt_q + {{N{1'b0}}, 1'b1};
            if (!err_vld_q) begin
                err_vld_d   = 1'b1;
                first_idx_d = vec_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            err_vld_q   <= 1'b0;
            first_idx_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_APPLY;
                        vec_q       <= '0;
                        hold_q      <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_cnt_q   <= '0;
                        err_vld_q   <= 1'b0;
                        first_idx_q <= '0;
                    end
                end
                S_APPLY: begin
                    err_cnt_q   <= err_cnt_d;
                    err_vld_q   <= err_vld_d;
                    first_idx_q <= first_idx_d;
                    if (sample) begin
                        hold_q <= '0;
                        if (vec_q == VEC_LAST) begin
                            // x keeps the last vector; pass uses the final tally.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                        end else begin
                            vec_q <= vec_q + 1'b1;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x             = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_cnt_q;
    assign err_valid     = err_vld_q;
    assign first_err_idx = first_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose : directed bench for truth_table_sweeper with a scoreboard of expected sweep results.
// Latency : two instances: defaults (majority, HOLD=20) and N=2/HOLD=1 with an XOR model.
// Backpressure: none; stimulus is a linear sequence in one initial block.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       start_a;
    logic [2:0] x_a;
    logic       f_a;
    logic       busy_a, done_a, pass_a, err_valid_a;
    logic [3:0] err_count_a;
    logic [2:0] first_err_idx_a;

    logic       start_b;
    logic [1:0] x_b;
    logic       f_b;
    logic       busy_b, done_b, pass_b, err_valid_b;
    logic [2:0] err_count_b;
    logic [1:0] first_err_idx_b;

    int  checks = 0;
    int  errors = 0;
    bit  inv_mode = 1'b0;
    int  fault_v = -1;

    typedef struct {
        logic [3:0] cnt;
        logic       vld;
        logic [2:0] idx;
        logic       pas;
    } exp_t;
    exp_t sb[$];

    truth_table_sweeper u_a (
        .clk(clk), .rst(rst), .start(start_a), .x(x_a), .f(f_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
        .err_valid(err_valid_a), .first_err_idx(first_err_idx_a)
    );

    truth_table_sweeper #(.N(2), .HOLD(1), .EXPECTED(4'b0110)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .x(x_b), .f(f_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
        .err_valid(err_valid_b), .first_err_idx(first_err_idx_b)
    );

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Lab-circuit models: majority with optional inversion / single-vector fault, and XOR.
    always_comb begin
        f_a = maj3(x_a) ^ inv_mode ^ ((fault_v >= 0) && (int'(x_a) == fault_v));
        f_b = x_b[0] ^ x_b[1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of a default-instance sweep, derived from the model settings.
    task automatic push_a(input bit inv, input int fv);
        exp_t e;
        logic [2:0] v;
        logic model_f, want;
        e.cnt = '0; e.vld = 1'b0; e.idx = '0;
        for (int i = 0; i < 8; i++) begin
            v       = 3'(i);
            model_f = maj3(v) ^ inv ^ (i == fv);
            want    = maj3(v);
            if (model_f != want) begin
                if (!e.vld) begin
                    e.vld = 1'b1;
                    e.idx = v;
                end
                e.cnt = e.cnt + 4'd1;
            end
        end
        e.pas = (e.cnt == 4'd0);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, input logic [3:0] cnt, input logic vld,
                             input logic [2:0] idx, input logic pas);
        exp_t e;
        chk({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_err_count"}, cnt, e.cnt);
            chk({tag, "_err_valid"}, vld, e.vld);
            chk({tag, "_pass"}, pas, e.pas);
            if (e.vld) chk({tag, "_first_idx"}, idx, e.idx);
        end
    endtask

    task automatic sweep_a(input string tag, input bit inv, input int fv, input bit poke);
        inv_mode = inv;
        fault_v  = fv;
        push_a(inv, fv);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk({tag, "_busy_start"}, busy_a, 1);
        chk({tag, "_done_clr"}, done_a, 0);
        chk({tag, "_cnt_clr"}, err_count_a, 0);
        chk({tag, "_vld_clr"}, err_valid_a, 0);
        for (int c = 1; c <= 160; c++) begin
            if ((c % 20 == 1) || (c % 20 == 0))
                chk({tag, "_x_step"}, x_a, (c - 1) / 20);
            if (c == 160) chk({tag, "_busy_last"}, busy_a, 1);
            if (poke && c == 50) start_a = 1'b1;
            tick();
            start_a = 1'b0;
        end
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_busy_end"}, busy_a, 0);
        chk({tag, "_x_hold"}, x_a, 7);
        pop_check(tag, err_count_a, err_valid_a, first_err_idx_a, pass_a);
    endtask

    initial begin
        exp_t eb;
        logic [3:0] exp_b;
        logic [1:0] vb;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        tick();
        // rst wins over a simultaneous start
        start_a = 1'b1;
        tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_x", x_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_cnt", err_count_a, 0);
        chk("rst_vld", err_valid_a, 0);
        chk("rst_idx", first_err_idx_a, 0);
        start_a = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_busy", busy_a, 0);

        sweep_a("good", 1'b0, -1, 1'b1);   // includes ignored start at vector 2
        sweep_a("fault5", 1'b0, 5, 1'b0);
        sweep_a("invert", 1'b1, -1, 1'b0); // starts from DONE after a failing run

        // Reset mid-sweep while vector 3 is driven.
        inv_mode = 1'b1; fault_v = -1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 65; c++) tick();
        chk("mid_x", x_a, 3);
        chk("mid_cnt", err_count_a, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_x", x_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_cnt", err_count_a, 0);
        chk("arst_vld", err_valid_a, 0);
        chk("arst_done", done_a, 0);
        tick();
        rst = 1'b0;
        tick();
        sweep_a("restart", 1'b0, -1, 1'b0);

        // Fast sweep on the N=2 / HOLD=1 instance.
        exp_b = 4'b0110;
        eb.cnt = '0; eb.vld = 1'b0; eb.idx = '0;
        for (int i = 0; i < 4; i++) begin
            vb = 2'(i);
            if ((vb[0] ^ vb[1]) != exp_b[i]) begin
                if (!eb.vld) begin eb.vld = 1'b1; eb.idx = 3'(i); end
                eb.cnt = eb.cnt + 4'd1;
            end
        end
        eb.pas = (eb.cnt == 4'd0);
        sb.push_back(eb);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("fast_x", x_b, c - 1);
            chk("fast_busy", busy_b, 1);
            tick();
        end
        chk("fast_done", done_b, 1);
        chk("fast_busy_end", busy_b, 0);
        pop_check("fast", {1'b0, err_count_b}, err_valid_b, {1'b0, first_err_idx_b}, pass_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
